// File: rtl/ifid_stage_if.sv
// ifid_stage_if: fetch-side memory handshake, hazard controls and IF/ID latch outputs
interface ifid_stage_if;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] raddr;
  logic        halt;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;
  modport slave (
    input  ihit, iload, stall, flush, redirect, raddr, halt,
    output iREN, iaddr, instr, npc, valid
  );
  modport master (
    output ihit, iload, stall, flush, redirect, raddr, halt,
    input  iREN, iaddr, instr, npc, valid
  );
endinterface

// File: rtl/ifid_stage.sv
// ifid_stage: program counter, instruction fetch request and IF/ID pipeline latch
module ifid_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input logic         CLK,
  input logic         nRST,
  ifid_stage_if.slave bus
);
  logic [31:0] pc, instr, npc, pc4;
  logic        halted, valid;
  assign pc4       = pc + 32'd4;
  assign bus.iaddr = pc;
  assign bus.iREN  = ~halted & ~bus.halt;
  assign bus.instr = instr;
  assign bus.npc   = npc;
  assign bus.valid = valid;
  // prioritised PC/latch update: halt > redirect > flush > stall > hit > miss
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      pc     <= PC_RESET;
      halted <= 1'b0;
      instr  <= '0;
      npc    <= '0;
      valid  <= 1'b0;
    end else if (halted | bus.halt) begin
      halted <= 1'b1;
      instr  <= '0;
      npc    <= '0;
      valid  <= 1'b0;
    end else if (bus.redirect) begin
      pc    <= {bus.raddr[31:2], 2'b00};
      instr <= '0;
      npc   <= '0;
      valid <= 1'b0;
    end else if (bus.flush) begin
      instr <= '0;
      npc   <= '0;
      valid <= 1'b0;
    end else if (!bus.stall) begin
      pc    <= bus.ihit ? pc4 : pc;
      instr <= bus.ihit ? bus.iload : '0;
      npc   <= bus.ihit ? pc4 : '0;
      valid <= bus.ihit;
    end
  end
endmodule
